nrs_gold_gen: RTL and testbench

NRS_GOLD_GEN -- requirements
Module: nrs_gold_gen

---
 rtl/nrs_pkg.sv | 27 ++
 rtl/nrs_lfsr31.sv | 45 ++++
 rtl/nrs_gold_gen.sv | 145 ++++++++++++++
 tb/tb_nrs_gold_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
// nrs_pkg -- shared constants and types for the NRS Gold-sequence generator.
//   NC_DEFAULT : default warm-up offset (shifts before the first output bit)
//   LFSR_LEN   : length of both Gold-sequence LFSRs
//   X1_TAPS    : feedback taps of x1, x1(n+31) = x1(n+3) ^ x1(n)
//   X2_TAPS    : feedback taps of x2, x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
//   X1_INIT    : x1 load value, x1(0)=1 and x1(1..30)=0
//   CUR_MASK   : selects the current element (bit 0) of an LFSR state
//   state_t    : generator FSM states
package nrs_pkg;

    localparam int NC_DEFAULT = 1600;
    localparam int LFSR_LEN   = 31;

    // Bit i of a tap mask feeds element n+i into the new element n+31.
    localparam logic [LFSR_LEN-1:0] X1_TAPS  = 31'h0000_0009;
    localparam logic [LFSR_LEN-1:0] X2_TAPS  = 31'h0000_000F;
    localparam logic [LFSR_LEN-1:0] X1_INIT  = 31'h0000_0001;
    localparam logic [LFSR_LEN-1:0] CUR_MASK = 31'h0000_0001;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        OUTPUT,
        DONE
    } state_t;

endpackage

// File: rtl/nrs_lfsr31.sv
// nrs_lfsr31 -- 31-bit Fibonacci LFSR, bit 0 holds the current element.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset, clears the state
//   load     : load load_val (takes priority over shift)
//   load_val : value to load
//   shift    : advance the sequence by one element
//   state    : current register contents
module nrs_lfsr31
    import nrs_pkg::*;
#(
    parameter logic [LFSR_LEN-1:0] TAPS = X1_TAPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [LFSR_LEN-1:0] load_val,
    input  logic                shift,
    output logic [LFSR_LEN-1:0] state
);

    logic [LFSR_LEN-1:0] state_reg;
    logic [LFSR_LEN-1:0] state_next;

    // Shifting right moves element n+1 into bit 0; the new element n+31
    // enters at the top as the parity of the tapped elements.
    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = load_val;
        end else if (shift) begin
            state_next = {^(state_reg & TAPS), state_reg[LFSR_LEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= '0;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/nrs_gold_gen.sv
// nrs_gold_gen -- Gold-sequence c(n) generator feeding an NRS register.
// After a start, both LFSRs are warmed up by NC shifts, then WIDTH_REG bits
// c(n) = x1(n+NC) ^ x2(n+NC) are written to addresses 0..WIDTH_REG-1.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   start   : one-cycle run request (accepted in IDLE)
//   c_init  : x2 initial state, sampled when start is accepted
//   c_n     : Gold-sequence bit (valid with wr_en)
//   wr_en   : downstream register write strobe
//   wr_addr : downstream register write address
//   busy    : high during warm-up and output
//   done    : one-cycle completion pulse
// Build option: define NRS_GOLD_RESTART_EN to let start in WARMUP/OUTPUT
// restart the run from the new c_init (the aborted run gives no done).
module nrs_gold_gen
    import nrs_pkg::*;
#(
    parameter int WIDTH_REG = 16,
    parameter int LINES     = $clog2(WIDTH_REG),
    parameter int NC        = NC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LFSR_LEN-1:0] c_init,
    output logic                c_n,
    output logic                wr_en,
    output logic [LINES-1:0]    wr_addr,
    output logic                busy,
    output logic                done
);

    localparam int WCW = $clog2(NC + 1);
    localparam logic [WCW-1:0]   WARM_LAST = WCW'(NC - 1);
    localparam logic [LINES-1:0] IDX_LAST  = LINES'(WIDTH_REG - 1);

    state_t              state_reg, state_next;
    logic [WCW-1:0]      warm_cnt_reg, warm_cnt_next;
    logic [LINES-1:0]    idx_reg, idx_next;
    logic                load;
    logic                shift;
    logic                cur_bit;
    logic [LFSR_LEN-1:0] x1_state;
    logic [LFSR_LEN-1:0] x2_state;

    nrs_lfsr31 #(.TAPS(X1_TAPS)) u_x1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (X1_INIT),
        .shift    (shift),
        .state    (x1_state)
    );

    nrs_lfsr31 #(.TAPS(X2_TAPS)) u_x2 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (c_init),
        .shift    (shift),
        .state    (x2_state)
    );

    // Current elements of x1 and x2 combined: c = x1[0] ^ x2[0].
    assign cur_bit = ^((x1_state ^ x2_state) & CUR_MASK);

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        idx_next      = idx_reg;
        load          = 1'b0;
        shift         = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        c_n           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    load          = 1'b1;
                    warm_cnt_next = '0;
                    idx_next      = '0;
                    state_next    = WARMUP;
                end
            end
            WARMUP: begin
                busy  = 1'b1;
                shift = 1'b1;
                // Counter runs 0..NC-1, so the NC-th shift is the last one.
                if (warm_cnt_reg == WARM_LAST) begin
                    warm_cnt_next = '0;
                    state_next    = OUTPUT;
                end else begin
                    warm_cnt_next = warm_cnt_reg + WCW'(1);
                end
            end
            OUTPUT: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = idx_reg;
                c_n     = cur_bit;
                shift   = 1'b1;
                if (idx_reg == IDX_LAST) begin
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + LINES'(1);
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef NRS_GOLD_RESTART_EN
        // A mid-run start replaces the run; outputs of this cycle stand.
        if (start && (state_reg == WARMUP || state_reg == OUTPUT)) begin
            load          = 1'b1;
            shift         = 1'b0;
            warm_cnt_next = '0;
            idx_next      = '0;
            state_next    = WARMUP;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            warm_cnt_reg <= '0;
            idx_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
            idx_reg      <= idx_next;
        end
    end

endmodule

// File: tb/tb_nrs_gold_gen.sv
// tb_nrs_gold_gen -- bench for nrs_gold_gen: a default instance (16 bits,
// NC=1600) and a small instance (8 bits, NC=4). A sequence model built from
// the x1/x2 recurrences predicts every output on every cycle; directed runs
// check timing, restart, reset and hand-derived bit patterns.
module tb_nrs_gold_gen;

    localparam int NA = 1600;
    localparam int WA = 16;
    localparam int NB = 4;
    localparam int WB = 8;
`ifdef NRS_GOLD_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [30:0] ci_a = '0, ci_b = '0;
    logic        c_n_a, wr_en_a, busy_a, done_a;
    logic [3:0]  wr_addr_a;
    logic        c_n_b, wr_en_b, busy_b, done_b;
    logic [2:0]  wr_addr_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nrs_gold_gen dut_a (
        .clk(clk), .rst(rst), .start(start_a), .c_init(ci_a),
        .c_n(c_n_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .busy(busy_a), .done(done_a)
    );

    nrs_gold_gen #(.WIDTH_REG(WB), .LINES(3), .NC(NB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .c_init(ci_b),
        .c_n(c_n_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .busy(busy_b), .done(done_b)
    );

    // ---------------- sequence model ----------------
    function automatic logic gold_x1(input int n);
        logic s [0:2047];
        for (int i = 0; i <= n; i++)
            s[i] = (i < 31) ? (i == 0) : (s[i-28] ^ s[i-31]);
        return s[n];
    endfunction

    function automatic logic gold_x2(input logic [30:0] ci, input int n);
        logic s [0:2047];
        for (int i = 0; i <= n; i++)
            s[i] = (i < 31) ? ci[i] : (s[i-28] ^ s[i-29] ^ s[i-30] ^ s[i-31]);
        return s[n];
    endfunction

    function automatic logic gold_bit(input logic [30:0] ci, input int n);
        return gold_x1(n) ^ gold_x2(ci, n);
    endfunction

    // Run tracker: t = clock edges since the accepting edge.
    bit   a_act = 1'b0, b_act = 1'b0;
    int   a_t = 0, b_t = 0;
    logic a_seq [0:WA-1];
    logic b_seq [0:WB-1];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_act <= 1'b0;
        end else if (start_a && (!a_act || (RESTART && a_t < NA + WA))) begin
            a_act <= 1'b1;
            a_t   <= 0;
            for (int n = 0; n < WA; n++) a_seq[n] <= gold_bit(ci_a, NA + n);
        end else if (a_act) begin
            a_t <= a_t + 1;
            if (a_t + 1 > NA + WA) a_act <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_act <= 1'b0;
        end else if (start_b && (!b_act || (RESTART && b_t < NB + WB))) begin
            b_act <= 1'b1;
            b_t   <= 0;
            for (int n = 0; n < WB; n++) b_seq[n] <= gold_bit(ci_b, NB + n);
        end else if (b_act) begin
            b_t <= b_t + 1;
            if (b_t + 1 > NB + WB) b_act <= 1'b0;
        end
    end

    // Per-cycle compare, {busy, done, wr_en, wr_addr, c_n}.
    always @(negedge clk) begin : cmp
        logic [7:0] ea, ga;
        logic [6:0] eb, gb;
        ea = '0;
        if (a_act) begin
            ea[7] = (a_t < NA + WA);
            ea[6] = (a_t == NA + WA);
            if (a_t >= NA && a_t < NA + WA) begin
                ea[5]   = 1'b1;
                ea[4:1] = 4'(a_t - NA);
                ea[0]   = a_seq[a_t - NA];
            end
        end
        ga = {busy_a, done_a, wr_en_a, wr_addr_a, c_n_a};
        checks++;
        if (ga !== ea) begin
            errors++;
            $display("FAIL cycle_a @%0d: got %b expected %b", cyc, ga, ea);
        end
        eb = '0;
        if (b_act) begin
            eb[6] = (b_t < NB + WB);
            eb[5] = (b_t == NB + WB);
            if (b_t >= NB && b_t < NB + WB) begin
                eb[4]   = 1'b1;
                eb[3:1] = 3'(b_t - NB);
                eb[0]   = b_seq[b_t - NB];
            end
        end
        gb = {busy_b, done_b, wr_en_b, wr_addr_b, c_n_b};
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL cycle_b @%0d: got %b expected %b", cyc, gb, eb);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge; acc = cycle count of the accepting edge.
    task automatic start_run(input bit sel, input logic [30:0] ci, output int acc);
        @(posedge clk);
        #1;
        if (sel) begin start_b = 1'b1; ci_b = ci; end
        else     begin start_a = 1'b1; ci_a = ci; end
        @(posedge clk);
        #1;
        acc = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int acc, input int budget,
                             output int off, output int busy_n, output logic [15:0] cap);
        off = -1;
        busy_n = 0;
        cap = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel ? busy_b : busy_a) busy_n++;
            if (sel ? wr_en_b : wr_en_a) begin
                if (sel) cap[wr_addr_b] = c_n_b;
                else     cap[wr_addr_a] = c_n_a;
            end
            if (sel ? done_b : done_a) begin
                off = cyc - acc;
                break;
            end
        end
        if (off < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [30:0] ci);
        logic [15:0] w;
        for (int n = 0; n < WA; n++) w[n] = gold_bit(ci, NA + n);
        return w;
    endfunction

    task automatic count_done(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done_a) cnt++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc, off, off1, bn, bn1, nd;
        logic [15:0] cap;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy_a, 0);
        chk("reset_wr_en", wr_en_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_c_n", c_n_a, 0);
        chk("reset_wr_addr", wr_addr_a, 0);
        @(negedge clk);
        rst = 1'b1;

        // Hand-derived values that pin the sequence model.
        chk("model_x1_31", gold_x1(31), 1);
        chk("model_x1_32", gold_x1(32), 0);
        chk("model_x1_62", gold_x1(62), 1);
        chk("model_x2_F_31", gold_x2(31'hF, 31), 0);
        chk("model_x2_F_32", gold_x2(31'hF, 32), 1);

        // c_init = 0: x2 stays zero, so c(n) is x1(1600+n).
        start_run(1'b0, 31'h0, acc);
        wait_done(1'b0, acc, 3000, off, bn, cap);
        chk("zero_done_offset", off, NA + WA);
        chk("zero_busy_cycles", bn, NA + WA);
        chk("zero_bits", cap, model_word(31'h0));

        // c_init = 0x12345, then a back-to-back run started right after done.
        start_run(1'b0, 31'h12345, acc);
        wait_done(1'b0, acc, 3000, off1, bn1, cap);
        chk("c12345_done_offset", off1, NA + WA);
        chk("c12345_busy_cycles", bn1, NA + WA);
        chk("c12345_bits", cap, model_word(31'h12345));
        start_run(1'b0, 31'h5A5A5A5, acc);
        wait_done(1'b0, acc, 3000, off, bn, cap);
        chk("b2b_done_offset", off, off1);
        chk("b2b_busy_cycles", bn, bn1);
        chk("b2b_bits", cap, model_word(31'h5A5A5A5));

        // Second start 800 edges into the run.
        start_run(1'b0, 31'h12345, acc);
        repeat (799) @(posedge clk);
        #1;
        start_a = 1'b1;
        ci_a = 31'h7;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_done(1'b0, acc, 4000, off, bn, cap);
        chk("restart_done_offset", off, RESTART ? 800 + NA + WA : NA + WA);
        chk("restart_bits", cap, model_word(RESTART ? 31'h7 : 31'h12345));
        count_done(1700, nd);
        chk("restart_single_done", nd, 0);

        // Reset during the output phase.
        start_run(1'b0, 31'h12345, acc);
        repeat (1605) @(posedge clk);
        #1;
        chk("pre_reset_wr_en", wr_en_a, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_wr_en", wr_en_a, 0);
        chk("midrst_c_n", c_n_a, 0);
        chk("midrst_wr_addr", wr_addr_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        count_done(30, nd);
        chk("midrst_no_done", nd, 0);
        start_run(1'b0, 31'h12345, acc);
        wait_done(1'b0, acc, 3000, off, bn, cap);
        chk("after_rst_done_offset", off, NA + WA);
        chk("after_rst_bits", cap, model_word(31'h12345));

        // Small instance, hand-derived: c(n) = x2(n+4) while x1(4..11)=0.
        start_run(1'b1, 31'h1, acc);
        wait_done(1'b1, acc, 100, off, bn, cap);
        chk("small_c1_done_offset", off, NB + WB);
        chk("small_c1_busy", bn, NB + WB);
        chk("small_c1_bits", cap, 16'h0000);
        start_run(1'b1, 31'h20, acc);
        wait_done(1'b1, acc, 100, off, bn, cap);
        chk("small_c20_bits", cap, 16'h0002);
        start_run(1'b1, 31'h7FFFFFFF, acc);
        wait_done(1'b1, acc, 100, off, bn, cap);
        chk("small_cff_done_offset", off, NB + WB);
        chk("small_cff_bits", cap, 16'h00FF);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
